// File: rtl/bnn_layer2_seq.sv
// Second BNN layer (8 inputs, 4 neurons): one neuron evaluated per cycle by XNOR-popcount and threshold.
// Latency is N_OUT edges from input acceptance; the result is held until out_ready_i, and in_ready_o stays low meanwhile.
module bnn_layer2_seq #(
  parameter int N_IN      = 8,
  parameter int N_OUT     = 4,
  parameter int THRESHOLD = 6,
  parameter int CNT_W     = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [N_IN-1:0]          in_act_i,
  input  logic                     wload_en_i,
  input  logic [3:0]               wload_nibble_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [N_OUT-1:0]         out_act_o,
  output logic [$clog2(N_OUT)-1:0] out_class_o,
  output logic                     busy_o
);

  localparam int IDX_W = $clog2(N_OUT);
  localparam logic [N_OUT*N_IN-1:0] W_RST = 32'h0FF7_62F9;

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_HOLD} state_t;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   act_q;
  logic [N_IN-1:0]   w_q [N_OUT];
  logic [IDX_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  ptr_q;
  logic              half_q;
  logic [3:0]        buf_q;
  logic [CNT_W-1:0]  max_q;
  logic [N_OUT-1:0]  out_act_q;
  logic [IDX_W-1:0]  out_class_q;

  logic              accept;
  logic              load;
  logic              last;
  logic [N_IN-1:0]   match_v;
  logic [CNT_W-1:0]  pc;

  // A weight nibble in IDLE takes priority over an incoming vector.
  assign accept  = (state_q == S_IDLE) && in_valid_i && !wload_en_i;
  assign load    = (state_q == S_IDLE) && wload_en_i;
  assign last    = (cnt_q == IDX_W'(N_OUT-1));
  assign match_v = ~(act_q ^ w_q[cnt_q]);

  always_comb begin
    pc = '0;
    for (int i = 0; i < N_IN; i++) pc = pc + CNT_W'(match_v[i]);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept) state_d = S_COMPUTE;
      S_COMPUTE: if (last) state_d = S_HOLD;
      S_HOLD:    if (out_ready_i) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (state_q == S_IDLE) && !wload_en_i;
    out_valid_o = (state_q == S_HOLD);
    busy_o      = (state_q != S_IDLE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      act_q       <= '0;
      cnt_q       <= '0;
      max_q       <= '0;
      out_act_q   <= '0;
      out_class_q <= '0;
    end else if (accept) begin
      act_q       <= in_act_i;
      cnt_q       <= '0;
      max_q       <= '0;
      out_act_q   <= '0;
      out_class_q <= '0;
    end else if (state_q == S_COMPUTE) begin
      out_act_q[cnt_q] <= (pc >= CNT_W'(THRESHOLD));
      // Strict compare: ties keep the lowest neuron index.
      if (cnt_q == '0 || pc > max_q) begin
        max_q       <= pc;
        out_class_q <= cnt_q;
      end
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // The half flag and buffer persist across COMPUTE/HOLD so a split pair completes later.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ptr_q  <= '0;
      half_q <= 1'b0;
      buf_q  <= '0;
      for (int k = 0; k < N_OUT; k++) w_q[k] <= W_RST[k*N_IN +: N_IN];
    end else if (load) begin
      if (!half_q) begin
        buf_q  <= wload_nibble_i;
        half_q <= 1'b1;
      end else begin
        w_q[ptr_q] <= {wload_nibble_i, buf_q};
        half_q     <= 1'b0;
        ptr_q      <= (ptr_q == IDX_W'(N_OUT-1)) ? '0 : ptr_q + 1'b1;
      end
    end
  end

  assign out_act_o   = out_act_q;
  assign out_class_o = out_class_q;

endmodule

// File: tb/tb_bnn_layer2_seq.sv
// Directed bench for bnn_layer2_seq with a transaction-level reference model checked every cycle.
module tb_bnn_layer2_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_act;
  logic       wload_en;
  logic [3:0] wload_nibble;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_act;
  logic [1:0] out_class;
  logic       busy;

  int checks = 0;
  int errors = 0;

  bnn_layer2_seq dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_act_i       (in_act),
    .wload_en_i     (wload_en),
    .wload_nibble_i (wload_nibble),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_act_o      (out_act),
    .out_class_o    (out_class),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 computing, 2 holding a result.
  logic [7:0] m_w [4];
  int         m_st, m_cnt, m_ptr;
  logic       m_half;
  logic [3:0] m_buf;
  logic [3:0] m_act;
  logic [1:0] m_cls;

  task automatic model_reset();
    m_w[0] = 8'hF9; m_w[1] = 8'h62; m_w[2] = 8'hF7; m_w[3] = 8'h0F;
    m_st = 0; m_cnt = 0; m_ptr = 0; m_half = 1'b0; m_buf = 4'h0;
    m_act = 4'h0; m_cls = 2'd0;
  endtask

  task automatic model_eval(input logic [7:0] a);
    int best;
    int pc;
    best = -1;
    for (int k = 0; k < 4; k++) begin
      pc = $countones(~(a ^ m_w[k]));
      m_act[k] = (pc >= 6);
      if (pc > best) begin
        best  = pc;
        m_cls = 2'(k);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) model_reset();
    chk("in_ready", in_ready, (m_st == 0) && !wload_en);
    chk("out_valid", out_valid, m_st == 2);
    chk("busy", busy, m_st != 0);
    if (m_st != 1) begin
      chk("out_act", out_act, m_act);
      chk("out_class", out_class, m_cls);
    end
    if (!reset) begin
      case (m_st)
        0: begin
          if (wload_en) begin
            if (!m_half) begin
              m_buf  = wload_nibble;
              m_half = 1'b1;
            end else begin
              m_w[m_ptr] = {wload_nibble, m_buf};
              m_half     = 1'b0;
              m_ptr      = (m_ptr + 1) % 4;
            end
          end else if (in_valid) begin
            model_eval(in_act);
            m_st  = 1;
            m_cnt = 4;
          end
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) m_st = 2;
        end
        default: if (out_ready) m_st = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] v);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_act   = v;
    #1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("send_ready_timeout", n < 50, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic load_nib(input logic [3:0] nib);
    wload_en     = 1'b1;
    wload_nibble = nib;
    tick();
    wload_en     = 1'b0;
  endtask

  task automatic wait_res(input string nm, input logic [3:0] ea, input logic [1:0] ec);
    int lat;
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    chk({nm, "_latency"}, lat, 4);
    chk({nm, "_act"}, out_act, ea);
    chk({nm, "_class"}, out_class, ec);
    if (out_ready) begin
      tick();
      chk({nm, "_valid_drop"}, out_valid, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_act = 8'h00;
    wload_en = 1'b0; wload_nibble = 4'h0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_act", out_act, 4'h0);
    chk("rst_out_class", out_class, 2'd0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;
    tick();

    send(8'hFF);  wait_res("ff_default", 4'b0101, 2'd2);
    send(8'h00);  wait_res("zero_default", 4'b0000, 2'd1);

    load_nib(4'hA); load_nib(4'h5);
    send(8'h5A);  wait_res("w0_loaded", 4'b0001, 2'd0);

    // Eight nibbles fill w1..w3 and then wrap to w0 (w0 := FF).
    load_nib(4'h2); load_nib(4'h6);
    load_nib(4'h7); load_nib(4'hF);
    load_nib(4'hF); load_nib(4'h0);
    load_nib(4'hF); load_nib(4'hF);
    send(8'hFF);  wait_res("ptr_wrap", 4'b0101, 2'd0);

    out_ready = 1'b0;
    send(8'h00);  wait_res("bp", 4'b0000, 2'd1);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_act = 8'hFF; wload_en = 1'b1; wload_nibble = 4'h3;
      tick();
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_act", out_act, 4'b0000);
      chk("bp_class", out_class, 2'd1);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0; wload_en = 1'b0; out_ready = 1'b1;
    tick();
    chk("bp_release", out_valid, 1'b0);

    in_valid = 1'b1; in_act = 8'hFF; wload_en = 1'b1; wload_nibble = 4'h9;
    #1;
    chk("simul_in_ready", in_ready, 1'b0);
    tick();
    chk("simul_no_compute", busy, 1'b0);
    wload_en = 1'b0;
    #1;
    chk("simul_ready_after", in_ready, 1'b1);
    tick();
    chk("simul_accepted", busy, 1'b1);
    in_valid = 1'b0;
    wait_res("simul", 4'b0101, 2'd0);

    // Complete the pending half pair: w1 := 8'h09.
    load_nib(4'h0);
    send(8'h09);  wait_res("half_pair", 4'b1010, 2'd1);

    send(8'hFF);
    tick();
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_act", out_act, 4'h0);
    chk("mid_rst_class", out_class, 2'd0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    tick();
    reset = 1'b0;
    tick();
    send(8'hFF);  wait_res("after_rst", 4'b0101, 2'd2);

    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
